// File: rtl/cache_control.sv
// Two-way set-associative cache controller: hit service, dirty-victim writeback and line refill.
// Optional hit/miss performance counters are built when CACHE_PERF_CNT_EN is defined.
module cache_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       mem_resp,
    input  logic       hit1,
    input  logic       hit2,
    input  logic       dirty1,
    input  logic       dirty2,
    input  logic       lru,
    output logic       pmem_read,
    output logic       pmem_write,
    input  logic       pmem_resp,
    output logic [1:0] load_way,
    output logic       wdata_sel,
    output logic       dirty_set,
    output logic       dirty_clr,
    output logic       lru_load,
    output logic       lru_val,
    output logic       pmem_addr_sel
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StFetch
    } state_e;

    state_e state_q, state_d;
    logic   victim_q, victim_d;
    logic   req, hit;

    assign req = mem_read | mem_write;
    assign hit = hit1 | hit2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // Outputs are gated by rst so they fall immediately, even with a hit pending on the inputs.
    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        load_way      = 2'b00;
        wdata_sel     = 1'b0;
        dirty_set     = 1'b0;
        dirty_clr     = 1'b0;
        lru_load      = 1'b0;
        lru_val       = 1'b0;
        pmem_addr_sel = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        lru_load = 1'b1;
                        lru_val  = hit1;
                        // A simultaneous read+write strobe is served as a write.
                        if (mem_write) begin
                            load_way  = hit1 ? 2'b01 : 2'b10;
                            dirty_set = 1'b1;
                        end
                    end else if (req) begin
                        victim_d = lru;
                        state_d  = (lru ? dirty2 : dirty1) ? StWriteback : StFetch;
                    end
                end
                StWriteback: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    if (pmem_resp) begin
                        dirty_clr = 1'b1;
                        state_d   = StFetch;
                    end
                end
                StFetch: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_way  = victim_q ? 2'b10 : 2'b01;
                        wdata_sel = 1'b1;
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             hit_inc, miss_inc;

    assign hit_inc  = (state_q == StIdle) && req && hit;
    assign miss_inc = (state_q == StIdle) && req && !hit;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_inc && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
        if (miss_inc && (miss_cnt_q != {CNT_W{1'b1}})) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    // Counters compiled out; CNT_W stays so instantiations are identical across builds.
    if (CNT_W == 0) begin : g_no_perf_cnt
    end
`endif

endmodule

// File: tb/tb_cache_control.sv
// Randomized/directed bench for cache_control against a transaction-level model of the
// hit/writeback/refill protocol; counter checks are built when CACHE_PERF_CNT_EN is defined.
module tb_cache_control;

    localparam int unsigned CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read, mem_write, mem_resp;
    logic       hit1, hit2, dirty1, dirty2, lru;
    logic       pmem_read, pmem_write, pmem_resp;
    logic [1:0] load_way;
    logic       wdata_sel, dirty_set, dirty_clr, lru_load, lru_val, pmem_addr_sel;
`ifdef CACHE_PERF_CNT_EN
    logic [CNT_W-1:0] hit_cnt, miss_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int hits_m = 0;
    int misses_m = 0;

    always #5 clk = ~clk;

    cache_control #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_resp     (mem_resp),
        .hit1         (hit1),
        .hit2         (hit2),
        .dirty1       (dirty1),
        .dirty2       (dirty2),
        .lru          (lru),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_resp    (pmem_resp),
        .load_way     (load_way),
        .wdata_sel    (wdata_sel),
        .dirty_set    (dirty_set),
        .dirty_clr    (dirty_clr),
        .lru_load     (lru_load),
        .lru_val      (lru_val),
        .pmem_addr_sel(pmem_addr_sel)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    logic [10:0] outs;
    assign outs = {mem_resp, pmem_read, pmem_write, load_way, wdata_sel, dirty_set, dirty_clr,
                   lru_load, lru_val, pmem_addr_sel};

    function automatic logic [10:0] vec(input bit resp, input bit pr, input bit pw,
                                        input logic [1:0] lw, input bit ws, input bit ds,
                                        input bit dc, input bit ll, input bit lv,
                                        input bit pas);
        return {resp, pr, pw, lw, ws, ds, dc, ll, lv, pas};
    endfunction

    // Hit service: respond, point LRU at the other way, and on writes update the hit way.
    function automatic logic [10:0] hit_vec(input bit is_write, input bit way1);
        logic [1:0] lw;
        lw = is_write ? (way1 ? 2'b01 : 2'b10) : 2'b00;
        return vec(1, 0, 0, lw, 0, is_write, 0, 1, way1, 0);
    endfunction

    function automatic int sat(input int n);
        int unsigned mx;
        mx = (1 << CNT_W) - 1;
        return (n > int'(mx)) ? int'(mx) : n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU transaction from IDLE, including any writeback/refill and the final hit.
    task automatic do_txn(input string tag, input bit rd, input bit wr, input bit h1,
                          input bit h2, input bit d1, input bit d2, input bit l,
                          input int wb_lat, input int f_lat, input bit drop);
        bit victim, vdirty, last;
        mem_read = rd; mem_write = wr;
        hit1 = h1; hit2 = h2; dirty1 = d1; dirty2 = d2; lru = l;
        pmem_resp = 0;
        #2;
        if (!(rd || wr)) begin
            check({tag, "_noreq"}, 32'(outs), 32'(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
            tick();
            return;
        end
        if (h1 || h2) begin
            check({tag, "_hit"}, 32'(outs), 32'(hit_vec(wr, h1)));
            hits_m++;
            tick();
            return;
        end
        check({tag, "_miss"}, 32'(outs), 32'(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        misses_m++;
        victim = l;
        vdirty = l ? d2 : d1;
        tick();
        if (drop) begin
            mem_read = 0;
            mem_write = 0;
        end
        hit1 = 0;
        hit2 = 0;
        if (vdirty) begin
            for (int i = 0; i < wb_lat; i++) begin
                last = (i == wb_lat - 1);
                lru = 1'($urandom); dirty1 = 1'($urandom); dirty2 = 1'($urandom);
                pmem_resp = last;
                #2;
                check({tag, "_wb"}, 32'(outs), 32'(vec(0, 0, 1, 0, 0, 0, last, 0, 0, 1)));
                tick();
            end
        end
        for (int i = 0; i < f_lat; i++) begin
            last = (i == f_lat - 1);
            lru = 1'($urandom); dirty1 = 1'($urandom); dirty2 = 1'($urandom);
            pmem_resp = last;
            #2;
            check({tag, "_fetch"}, 32'(outs),
                  32'(vec(0, 1, 0, last ? (victim ? 2'b10 : 2'b01) : 2'b00, last, 0, 0, 0, 0,
                          0)));
            tick();
        end
        pmem_resp = 0;
        hit1 = !victim;
        hit2 = victim;
        #2;
        if (drop) begin
            check({tag, "_dropped"}, 32'(outs), 32'(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        end else begin
            check({tag, "_refill_hit"}, 32'(outs), 32'(hit_vec(wr, !victim)));
            hits_m++;
        end
        tick();
    endtask

    initial begin
        rst = 1;
        mem_read = 1; mem_write = 0; hit1 = 1; hit2 = 0;
        dirty1 = 0; dirty2 = 0; lru = 0; pmem_resp = 0;
        #2;
        check("reset_outputs", 32'(outs), 32'(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
`ifdef CACHE_PERF_CNT_EN
        check("reset_hit_cnt", 32'(hit_cnt), 32'(0));
        check("reset_miss_cnt", 32'(miss_cnt), 32'(0));
`endif
        tick();
        tick();
        mem_read = 0; hit1 = 0;
        rst = 0;
        tick();

        do_txn("read_hit_way2", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        do_txn("write_hit_both", 0, 1, 1, 1, 1, 0, 1, 0, 0, 0);
        do_txn("rdwr_hit_way2", 1, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        do_txn("clean_miss", 1, 0, 0, 0, 0, 0, 1, 0, 3, 0);
        do_txn("dirty_miss", 1, 0, 0, 0, 1, 0, 0, 2, 3, 0);
        do_txn("dirty_miss_wr", 0, 1, 0, 0, 0, 1, 1, 1, 1, 0);
        do_txn("drop_miss", 1, 0, 0, 0, 1, 1, 0, 2, 2, 1);

        for (int t = 0; t < 40; t++) begin
            do_txn("rand", 1'($urandom), 1'($urandom), ($urandom % 3) == 0,
                   ($urandom % 3) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                   ($urandom % 4) == 0);
        end
`ifdef CACHE_PERF_CNT_EN
        check("rand_hit_cnt", 32'(hit_cnt), 32'(sat(hits_m)));
        check("rand_miss_cnt", 32'(miss_cnt), 32'(sat(misses_m)));
`endif

        // Reset in the middle of a refill.
        mem_read = 1; mem_write = 0; hit1 = 0; hit2 = 0; lru = 1; dirty2 = 0; pmem_resp = 0;
        #2;
        tick();
        #2;
        check("pre_rst_fetch", 32'(outs), 32'(vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
        #1;
        rst = 1;
        hit1 = 1;
        #1;
        check("rst_mid_fetch", 32'(outs), 32'(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
`ifdef CACHE_PERF_CNT_EN
        check("rst_hit_cnt", 32'(hit_cnt), 32'(0));
        check("rst_miss_cnt", 32'(miss_cnt), 32'(0));
`endif
        hits_m = 0;
        misses_m = 0;
        tick();
        mem_read = 0; hit1 = 0;
        rst = 0;
        tick();
        do_txn("post_rst_hit", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_txn("post_rst_miss", 0, 1, 0, 0, 1, 0, 0, 1, 2, 0);

        for (int t = 0; t < 20; t++) begin
            do_txn("burst_hit", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        end
`ifdef CACHE_PERF_CNT_EN
        check("hit_cnt_saturated", 32'(hit_cnt), 32'(sat(hits_m)));
        check("hit_cnt_all_ones", 32'(hit_cnt), 32'(15));
        check("miss_cnt_final", 32'(miss_cnt), 32'(sat(misses_m)));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of performance counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have ports mem_read, mem_write  input  1 each  CPU request strobes, held until mem_resp.
REQ-005 SHALL have port mem_resp  output  1  CPU request complete.
REQ-006 SHALL have ports hit1, hit2, dirty1, dirty2  input  1 each  per-way tag-match and dirty status for the addressed set.
REQ-007 SHALL have port lru  input  1  least-recently-used way of the addressed set (0=way1, 1=way2).
REQ-008 SHALL have ports pmem_read, pmem_write  output  1 each, and pmem_resp  input  1  physical-memory line handshake.
REQ-009 SHALL have port load_way  output  2  one-hot data/tag/valid array write enable ([0]=way1, [1]=way2).
REQ-010 SHALL have port wdata_sel  output  1  array write source (0=merged CPU write data, 1=pmem line).
REQ-011 SHALL have ports dirty_set, dirty_clr, lru_load, lru_val  output  1 each  dirty and LRU array control for way selected by load_way/victim.
REQ-012 SHALL have port pmem_addr_sel  output  1  (0=CPU line address, 1=victim tag line address).
REQ-013 SHALL have ports hit_cnt, miss_cnt  output  CNT_W each (only under CACHE_PERF_CNT_EN).

Function
REQ-014 SHALL implement FSM states IDLE, WRITEBACK, FETCH; all outputs not named below SHALL be 0.
REQ-015 In IDLE with request and hit, SHALL assert mem_resp combinationally in the same cycle; hit1 has priority when hit1 and hit2 both high.
REQ-016 On read or write hit, SHALL assert lru_load with lru_val = non-hit way (hit1 -> 1, hit2 -> 0).
REQ-017 On write hit, SHALL assert load_way for the hit way, wdata_sel=0, dirty_set=1.
REQ-018 If mem_read and mem_write are both high, SHALL treat the request as a write.
REQ-019 On IDLE miss, SHALL latch victim_q=lru; next state is WRITEBACK if the victim's dirty bit is 1, else FETCH.
REQ-020 WRITEBACK SHALL assert pmem_write and pmem_addr_sel=1 until pmem_resp; on pmem_resp, SHALL pulse dirty_clr for victim_q and go to FETCH.
REQ-021 FETCH SHALL assert pmem_read with pmem_addr_sel=0 until pmem_resp; on pmem_resp, SHALL pulse load_way=one-hot(victim_q) with wdata_sel=1 and return to IDLE.
REQ-022 After refill, IDLE SHALL re-evaluate and serve the request as a hit; clean-miss latency = fetch cycles + 1, dirty-miss latency = writeback + fetch cycles + 1.
REQ-023 If the CPU drops the request mid-miss, SHALL complete the outstanding pmem transaction and then return to IDLE; it SHALL NOT abort.
REQ-024 pmem_read and pmem_write SHALL never be asserted in the same cycle.

Reset
REQ-025 rst SHALL force IDLE, victim_q=0, counters=0, and all outputs to 0 asynchronously, including mid-WRITEBACK or mid-FETCH.
REQ-026 After rst deasserts, the first rising edge SHALL evaluate IDLE normally.

Configuration
REQ-027 With CACHE_PERF_CNT_EN defined, hit_cnt SHALL increment on each IDLE cycle with request and hit; miss_cnt SHALL increment on each IDLE->WRITEBACK/FETCH transition; both SHALL saturate at all-ones.
REQ-028 Without CACHE_PERF_CNT_EN, hit_cnt/miss_cnt ports and counter flops SHALL be absent, with no other behavioural change.

Verification
REQ-029 Read hit: mem_read=1, hit2=1 -> mem_resp=1 same cycle, lru_load=1, lru_val=0, pmem idle.
REQ-030 Write hit, both ways hit: mem_write=1, hit1=hit2=1 -> load_way=01, wdata_sel=0, dirty_set=1, mem_resp=1.
REQ-031 Clean miss: mem_read=1, no hit, lru=1, dirty2=0, pmem_resp after 3 cycles -> FETCH 3 cycles, load_way=10, wdata_sel=1, mem_resp asserted on the next cycle with hit2=1.
REQ-032 Dirty miss: lru=0, dirty1=1 -> WRITEBACK with pmem_addr_sel=1, dirty_clr pulse, FETCH, load_way=01; total latency = wb + fetch + 1.
REQ-033 rst asserted mid-FETCH -> pmem_read drops without waiting for a clock edge, state IDLE, counters 0.
REQ-034 With CACHE_PERF_CNT_EN and CNT_W=4: 20 hits -> hit_cnt holds 15.
